// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage:
//     WIDTH         - datapath / address width
//     RESET_VECTOR  - PC loaded on reset
//     fetch_state_e - fetch FSM states (2-bit encodings)
//     pc_inc        - PC increment, modulo 2^WIDTH
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int WIDTH = 32;

    localparam logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ    = 2'b00,
        FETCH_VALID  = 2'b01,
        FETCH_HALTED = 2'b10
    } fetch_state_e;

    // Wraps silently from all-ones to zero.
    function automatic logic [WIDTH-1:0] pc_inc(input logic [WIDTH-1:0] pc);
        return pc + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding decoder_unit. Holds the PC, requests one
//   word at a time from instruction memory (req/ack), presents the returned
//   word and its PC to the decoder (valid/ready), follows redirects (squashing
//   an in-flight fetch if needed) and stops after a HALT is consumed.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   imem_req     out  instruction memory request
//   imem_addr    out  word address of the request
//   imem_ack     in   memory response strobe (only while imem_req=1)
//   imem_rdata   in   instruction word, valid with imem_ack
//   inst         out  instruction to decoder
//   inst_pc      out  PC of inst
//   inst_valid   out  inst/inst_pc valid
//   inst_ready   in   decoder consumes inst this cycle
//   halt         in   presented inst is a HALT
//   redirect     in   change PC and flush the fetched instruction
//   redirect_pc  in   redirect target
//   fetch_halted out  HALT consumed, fetch stopped
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WIDTH-1:0] RESET_PC = RESET_VECTOR
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic             halt,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             fetch_halted
);

    fetch_state_e     r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_req_addr;
    logic             r_squash;

    fetch_state_e     w_state_nxt;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_req_addr_nxt;
    logic             w_squash_nxt;
    logic             w_capture;
    logic             w_valid_nxt;
    logic             w_halted_nxt;
    logic             w_ack;

    // An ack is only meaningful while a request is actually on the bus.
    assign w_ack = imem_ack & imem_req;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_squash_nxt   = r_squash;
        w_capture      = 1'b0;
        w_valid_nxt    = inst_valid;
        w_halted_nxt   = fetch_halted;

        case (r_state)
            FETCH_REQ: begin
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                    if (w_ack) begin
                        // Returned word is wrong-path; refetch from the target.
                        w_squash_nxt   = 1'b0;
                        w_req_addr_nxt = redirect_pc;
                    end else begin
                        // Let the outstanding request finish at its old
                        // address, then throw its data away. A later redirect
                        // only moves pc, so the newest target is refetched.
                        w_squash_nxt = 1'b1;
                    end
                end else if (w_ack) begin
                    if (r_squash) begin
                        w_squash_nxt   = 1'b0;
                        w_req_addr_nxt = r_pc;
                    end else begin
                        w_capture   = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = pc_inc(r_req_addr);
                        w_state_nxt = FETCH_VALID;
                    end
                end
            end

            FETCH_VALID: begin
                // Redirect wins over ready/halt: a same-cycle HALT is wrong-path.
                if (redirect) begin
                    w_pc_nxt       = redirect_pc;
                    w_req_addr_nxt = redirect_pc;
                    w_valid_nxt    = 1'b0;
                    w_state_nxt    = FETCH_REQ;
                end else if (inst_ready) begin
                    w_valid_nxt = 1'b0;
                    if (halt) begin
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = FETCH_HALTED;
                    end else begin
                        w_req_addr_nxt = r_pc;
                        w_state_nxt    = FETCH_REQ;
                    end
                end
            end

            FETCH_HALTED: begin
                w_valid_nxt  = 1'b0;
                w_halted_nxt = 1'b1;
            end

            default: begin
                w_state_nxt = FETCH_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FETCH_REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_squash   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_squash   <= w_squash_nxt;
        end
    end

    // Outputs are registered from the next-state values so imem_req rises and
    // falls in the same cycle the FSM enters or leaves REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req     <= 1'b0;
            imem_addr    <= '0;
            inst         <= '0;
            inst_pc      <= '0;
            inst_valid   <= 1'b0;
            fetch_halted <= 1'b0;
        end else begin
            imem_req     <= (w_state_nxt == FETCH_REQ);
            imem_addr    <= w_req_addr_nxt;
            inst_valid   <= w_valid_nxt;
            fetch_halted <= w_halted_nxt;
            if (w_capture) begin
                inst    <= imem_rdata;
                inst_pc <= r_req_addr;
            end
        end
    end

endmodule
